// File: rtl/mc_pkg.sv
// Shared definitions for the memory transfer buffer.
//   DATA_W_DEF / DEPTH_DEF : default data width and word count
//   clog2()                : pointer width for a power-of-two depth
//   occ_w()                : width of an occupancy counter that must reach DEPTH
package mc_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Smallest r with 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
    function automatic int occ_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mc_ptr.sv
// Auto-incrementing wrap counter used as a buffer pointer.
//   clock : rising-edge clock
//   Reset : synchronous active-high clear
//   Inc   : advance by one this cycle
//   Value : current pointer; wraps from 2**W-1 to 0 naturally
module mc_ptr #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Value
);

    logic [W-1:0] value_reg;

    always_ff @(posedge clock) begin
        if (Reset) begin
            value_reg <= '0;
        end else if (Inc) begin
            value_reg <= value_reg + 1'b1;
        end
    end

    assign Value = value_reg;

endmodule

// File: rtl/mc_xfer_buf.sv
// Memory transfer buffer: DEPTH x DATA_W storage with independent write and
// read pointers, occupancy tracking and sticky error flags.
//   clock, Reset        : single clock, synchronous active-high reset
//   WEA, WrValid, DataInA : write request, data qualifier, write data
//   RdEn                : read request
//   DOut1, DOutValid    : registered read data and its one-cycle valid pulse
//   AddrW, AddrR        : current write / read pointers
//   Count, Full, Empty  : occupancy and its decoded flags
//   OvfErr, UdfErr      : sticky write-while-full / read-while-empty flags
module mc_xfer_buf
    import mc_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = clog2(DEPTH),
    localparam int OCC_W  = occ_w(DEPTH)
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              WEA,
    input  logic              WrValid,
    input  logic [DATA_W-1:0] DataInA,
    input  logic              RdEn,
    output logic [DATA_W-1:0] DOut1,
    output logic              DOutValid,
    output logic [ADDR_W-1:0] AddrW,
    output logic [ADDR_W-1:0] AddrR,
    output logic [OCC_W-1:0]  Count,
    output logic              Full,
    output logic              Empty,
    output logic              OvfErr,
    output logic              UdfErr
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [OCC_W-1:0]  count_reg;
    logic [OCC_W-1:0]  count_next;
    logic [DATA_W-1:0] dout_reg;
    logic              dvalid_reg;
    logic              ovf_reg;
    logic              udf_reg;

    logic              full;
    logic              empty;
    logic              wr_req;
    logic              wr_acc;
    logic              rd_acc;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign full   = (count_reg == OCC_W'(DEPTH));
    assign empty  = (count_reg == '0);
    assign wr_req = WEA && WrValid;

    // Full and empty are mutually exclusive, so a write and a read accepted
    // together never address the same word; no bypass path is needed.
    assign wr_acc = wr_req && !full;
    assign rd_acc = RdEn && !empty;

    mc_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clock (clock),
        .Reset (Reset),
        .Inc   (wr_acc),
        .Value (wr_ptr)
    );

    mc_ptr #(.W(ADDR_W)) u_rd_ptr (
        .clock (clock),
        .Reset (Reset),
        .Inc   (rd_acc),
        .Value (rd_ptr)
    );

    // Storage is not cleared by reset; reset only blocks the write on its edge.
    always_ff @(posedge clock) begin
        if (!Reset && wr_acc) begin
            mem[wr_ptr] <= DataInA;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            count_reg  <= '0;
            dout_reg   <= '0;
            dvalid_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            count_reg  <= count_next;
            dvalid_reg <= rd_acc;
            if (rd_acc) begin
                dout_reg <= mem[rd_ptr];
            end
            if (wr_req && full) begin
                ovf_reg <= 1'b1;
            end
            if (RdEn && empty) begin
                udf_reg <= 1'b1;
            end
        end
    end

    assign DOut1     = dout_reg;
    assign DOutValid = dvalid_reg;
    assign AddrW     = wr_ptr;
    assign AddrR     = rd_ptr;
    assign Count     = count_reg;
    assign Full      = full;
    assign Empty     = empty;
    assign OvfErr    = ovf_reg;
    assign UdfErr    = udf_reg;

endmodule

// File: doc/mc_xfer_buf.md
Name: mc_xfer_buf

Overview:
- Parametrised successor to the single-pointer memory controller. Internal DEPTH x DATA_W memory with independent auto-incrementing write and read pointers.
- Occupancy tracking, full/empty flags, a registered read-valid handshake and sticky error flags.
- Sits between the source-side and sink-side of the memory transfer path.
- The explicit WrValid qualifier replaces the old high-impedance data check.

Parameters:
- DATA_W, 8, data width in bits.
- DEPTH, 8, number of words; power of two, >= 2.
- ADDR_W, clog2(DEPTH), derived localparam, pointer width. Not user-settable.

Ports:
- clock     in   1          single system clock, rising edge.
- Reset     in   1          synchronous, active-high reset.
- WEA       in   1          write request.
- WrValid   in   1          DataInA qualifier; a write requires WEA && WrValid.
- DataInA   in   DATA_W     write data.
- RdEn      in   1          read request.
- DOut1     out  DATA_W     read data, registered.
- DOutValid out  1          DOut1 holds newly read data this cycle.
- AddrW     out  ADDR_W     current write pointer.
- AddrR     out  ADDR_W     current read pointer.
- Count     out  ADDR_W+1   occupied words, 0..DEPTH.
- Full      out  1          Count == DEPTH.
- Empty     out  1          Count == 0.
- OvfErr    out  1          sticky: a write was attempted while Full.
- UdfErr    out  1          sticky: a read was attempted while Empty.

Behaviour:
- The clock is the single clock. Reset is synchronous and active-high, sampled on the rising edge of the clock, and has priority over all other inputs.
- Reset values:
  - AddrW=0, AddrR=0, Count=0, DOut1=0, DOutValid=0, OvfErr=0, UdfErr=0.
  - Full=0, Empty=1.
  - Memory contents are not cleared.
- Write accept: wr_acc = WEA && WrValid && !Full, evaluated with pre-edge state.
  - On accept: mem[AddrW] <= DataInA; AddrW <= AddrW+1, wrapping modulo DEPTH.
- Read accept: rd_acc = RdEn && !Empty, evaluated with pre-edge state.
  - On accept: DOut1 <= mem[AddrR]; AddrR <= AddrR+1, wrapping modulo DEPTH.
  - DOutValid <= rd_acc every cycle, so it is a one-cycle pulse per accepted read.
  - Latency is one clock from RdEn sample to DOut1/DOutValid.
  - DOut1 holds its last value when no read is accepted.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Full and Empty are decoded combinationally from the registered Count.
- Simultaneous events:
  - Full with both requested: read accepted, write rejected (no pass-through); OvfErr set.
  - Empty with both requested: write accepted, read rejected (no bypass); UdfErr set; DOutValid=0 next cycle.
  - Both accepted with AddrW==AddrR: impossible, since that case is either full or empty.
- Errors:
  - OvfErr <= 1 when WEA && WrValid && Full.
  - UdfErr <= 1 when RdEn && Empty.
  - Both clear only on Reset.
  - A rejected request changes no pointer, Count, or memory word.
- WEA without WrValid is ignored silently; no error is raised.
- Reset mid-operation: pointers, Count and flags return to reset values on that edge. Any in-flight read result is discarded (DOutValid=0).
- Wrap-around: pointers roll from DEPTH-1 to 0 with no extra cycle.

Decomposition:
- Shared package mc_pkg holds:
  - default DATA_W/DEPTH constants;
  - a clog2 function;
  - an occupancy-type width helper for ADDR_W+1 counters.
- One sub-module, mc_ptr: an ADDR_W auto-incrementing wrap counter with inc and sync reset. It is instantiated twice, for write and read.
- Memory array, Count and flags stay in mc_xfer_buf.

Test Plan:
- Reset then 8 writes of 0x11..0x88 with WrValid=1 (DEPTH=8) -> Count steps 1..8; Full=1 after the 8th; AddrW wraps to 0; OvfErr=0.
- From that full state, 8 reads -> DOut1 = 0x11..0x88 in order, each one cycle after RdEn with DOutValid=1; Empty=1 at the end; AddrR=0.
- Write 0xAA while Full -> memory, AddrW and Count unchanged; OvfErr=1 and stays 1 until Reset. RdEn while Empty -> UdfErr=1, DOutValid=0.
- Count=3, WEA+WrValid+RdEn together -> Count stays 3; both pointers advance by 1; oldest word is output next cycle.
- Empty, simultaneous write 0x5C and read -> read rejected (DOutValid=0), UdfErr=1, Count=1. A read next cycle returns 0x5C.
- Reset asserted mid-burst at Count=5 with RdEn=1 -> next cycle Count=0, Empty=1, DOutValid=0, AddrW=AddrR=0, OvfErr=UdfErr=0. WEA=1 with WrValid=0 -> no write, no error.
